// File: rtl/flappy_core_param.sv
// Game core for the LED-matrix flappy-bird: bird motion, scrolling trees, collision,
// round/score bookkeeping and an IDLE/PLAY/PAUSE/DEAD controller, all parametrised.
module flappy_core_param #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int NUM_TREES    = 3,
  parameter int TREE_SPACING = 6,
  parameter int BIRD_COL     = 3,
  parameter int TICK_DIV     = 1024,
  parameter int DEAD_STEPS   = 8,
  parameter int SCORE_DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      up,
  input  logic [NUM_TREES*ROWS-1:0] tree_pattern,
  output logic [ROWS*COLS-1:0]      red_pixels,
  output logic [ROWS*COLS-1:0]      grn_pixels,
  output logic [$clog2(ROWS)-1:0]   bird_row,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score,
  output logic                      win,
  output logic                      die,
  output logic                      step,
  output logic [1:0]                state
);

  localparam int ROUND_LEN = (NUM_TREES-1)*TREE_SPACING + COLS;
  localparam int RW  = $clog2(ROWS);
  localparam int TW  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW  = (ROUND_LEN > 1)  ? $clog2(ROUND_LEN)  : 1;
  localparam int DW  = (DEAD_STEPS > 1) ? $clog2(DEAD_STEPS) : 1;
  localparam int SCW = 4*SCORE_DIGITS;
  localparam int PW  = NUM_TREES*ROWS;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV-1);
  localparam logic [RW-1:0]  ROW_TOP   = RW'(ROWS-1);
  localparam logic [RW-1:0]  ROW_MID   = RW'(ROWS/2);
  localparam logic [SW-1:0]  RS_LAST   = SW'(ROUND_LEN-1);
  localparam logic [DW-1:0]  DEAD_LAST = DW'(DEAD_STEPS-1);
  localparam logic [SCW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, DEAD = 2'd3} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [SW-1:0]  rs_q, rs_d;
  logic [DW-1:0]  dead_q, dead_d;
  logic [RW-1:0]  row_q, row_d;
  logic           latch_q, latch_d;
  logic [PW-1:0]  pat_q, pat_d;
  logic [SCW-1:0] score_q, score_d;
  logic [SCW-1:0] hi_q, hi_d;
  logic           win_q, win_d;
  logic           die_q, die_d;

  logic           counting, step_w, fall, hit, death;
  logic [RW-1:0]  row_next;
  logic [SW-1:0]  rs_next;

  // A tree sits on the bird column exactly when its scroll offset puts it there.
  function automatic logic tree_hit(input logic [SW-1:0] rs, input logic [PW-1:0] pat,
                                    input logic [RW-1:0] row);
    tree_hit = 1'b0;
    for (int i = 0; i < NUM_TREES; i++) begin
      if (int'(rs) == i*TREE_SPACING + (COLS-1-BIRD_COL) && pat[i*ROWS + int'(row)])
        tree_hit = 1'b1;
    end
  endfunction

  function automatic logic [SCW-1:0] bcd_inc(input logic [SCW-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    if (v != ALL_NINES) begin
      for (int d = 0; d < SCORE_DIGITS; d++) begin
        if (carry) begin
          if (v[4*d +: 4] == 4'd9) begin
            bcd_inc[4*d +: 4] = 4'd0;
          end else begin
            bcd_inc[4*d +: 4] = v[4*d +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  endfunction

  assign counting = (state_q == PLAY) || (state_q == DEAD);
  assign step_w   = counting && (tick_q == TICK_LAST);

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d  = state_q;
    tick_d   = tick_q;
    rs_d     = rs_q;
    dead_d   = dead_q;
    row_d    = row_q;
    latch_d  = latch_q;
    pat_d    = pat_q;
    score_d  = score_q;
    hi_d     = hi_q;
    win_d    = 1'b0;
    die_d    = 1'b0;
    fall     = 1'b0;
    hit      = 1'b0;
    death    = 1'b0;
    row_next = row_q;
    rs_next  = rs_q;

    if (counting) tick_d = step_w ? '0 : tick_q + 1'b1;
    // A flap seen on the step cycle itself survives to the following step.
    if (step_w) latch_d = 1'b0;
    if (state_q == PLAY && up) latch_d = 1'b1;

    case (state_q)
      IDLE:  if (run) state_d = PLAY;
      PAUSE: if (run) state_d = PLAY;
      PLAY: begin
        if (step_w) begin
          fall     = !latch_q && (row_q == '0);
          row_next = latch_q ? ((row_q == ROW_TOP) ? ROW_TOP : row_q + 1'b1) : row_q - 1'b1;
          rs_next  = (rs_q == RS_LAST) ? '0 : rs_q + 1'b1;
          hit      = tree_hit(rs_next, pat_q, row_next);
          death    = fall || hit;
          if (death) begin
            state_d = DEAD;
            die_d   = 1'b1;
            score_d = '0;
            row_d   = ROW_MID;
            rs_d    = '0;
            dead_d  = '0;
            pat_d   = tree_pattern;
          end else begin
            row_d = row_next;
            rs_d  = rs_next;
            if (rs_q == RS_LAST) begin
              win_d   = 1'b1;
              score_d = bcd_inc(score_q);
              pat_d   = tree_pattern;
              if (score_d > hi_q) hi_d = score_d;
            end
          end
        end else if (!run) begin
          state_d = PAUSE;
        end
      end
      DEAD: begin
        if (step_w) begin
          if (dead_q == DEAD_LAST) begin
            state_d = IDLE;
            dead_d  = '0;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      rs_q    <= '0;
      dead_q  <= '0;
      row_q   <= ROW_MID;
      latch_q <= 1'b0;
      pat_q   <= tree_pattern;
      score_q <= '0;
      hi_q    <= '0;
      win_q   <= 1'b0;
      die_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      tick_q  <= tick_d;
      rs_q    <= rs_d;
      dead_q  <= dead_d;
      row_q   <= row_d;
      latch_q <= latch_d;
      pat_q   <= pat_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      win_q   <= win_d;
      die_q   <= die_d;
    end
  end

  always_comb begin
    red_pixels = '0;
    grn_pixels = '0;
    if (state_q != DEAD) begin
      red_pixels[int'(row_q)*COLS + BIRD_COL] = 1'b1;
      for (int i = 0; i < NUM_TREES; i++) begin
        if (int'(rs_q) >= i*TREE_SPACING && int'(rs_q) <= i*TREE_SPACING + COLS-1) begin
          for (int r = 0; r < ROWS; r++)
            grn_pixels[r*COLS + (COLS-1-(int'(rs_q)-i*TREE_SPACING))] = pat_q[i*ROWS + r];
        end
      end
    end
  end

  assign bird_row = row_q;
  assign score    = score_q;
  assign hi_score = hi_q;
  assign win      = win_q;
  assign die      = die_q;
  assign step     = step_w;
  assign state    = state_q;

endmodule

// File: tb/tb_flappy_core_param.sv
// Scoreboard bench for flappy_core_param: expected post-step snapshots are queued by the
// stimulus and a negedge monitor compares them one cycle after every step pulse.
module tb_flappy_core_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, run, up;
  logic [47:0]   tree_pattern;
  logic [255:0]  red_pixels, grn_pixels;
  logic [3:0]    bird_row;
  logic [11:0]   score, hi_score;
  logic          win, die, step;
  logic [1:0]    state;

  logic          reset1, run1, up1;
  logic [47:0]   tree_pattern1;
  logic [255:0]  red_pixels1, grn_pixels1;
  logic [3:0]    bird_row1;
  logic [3:0]    score1, hi_score1;
  logic          win1, die1, step1;
  logic [1:0]    state1;

  flappy_core_param #(.TICK_DIV(4), .DEAD_STEPS(2)) dut (
    .clock(clock), .reset(reset), .run(run), .up(up), .tree_pattern(tree_pattern),
    .red_pixels(red_pixels), .grn_pixels(grn_pixels), .bird_row(bird_row),
    .score(score), .hi_score(hi_score), .win(win), .die(die), .step(step), .state(state)
  );

  flappy_core_param #(.TICK_DIV(4), .DEAD_STEPS(2), .SCORE_DIGITS(1)) dut1 (
    .clock(clock), .reset(reset1), .run(run1), .up(up1), .tree_pattern(tree_pattern1),
    .red_pixels(red_pixels1), .grn_pixels(grn_pixels1), .bird_row(bird_row1),
    .score(score1), .hi_score(hi_score1), .win(win1), .die(die1), .step(step1), .state(state1)
  );

  typedef struct {
    logic [3:0]   row;
    logic [1:0]   st;
    logic [11:0]  sc;
    logic [11:0]  hi;
    logic         w;
    logic         d;
    logic [255:0] grn;
  } exp_t;

  typedef struct {
    logic [3:0] sc;
    logic [3:0] hi;
  } exp1_t;

  exp_t  exp_q[$];
  exp1_t exp1_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    win1_cnt  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] col_mask(input int c, input logic [15:0] pat);
    col_mask = '0;
    for (int r = 0; r < 16; r++) col_mask[r*16 + c] = pat[r];
  endfunction

  function automatic logic [255:0] bird_px(input int row);
    bird_px = '0;
    bird_px[row*16 + 3] = 1'b1;
  endfunction

  task automatic push(input int row, input int st, input int sc, input int hi,
                      input logic w, input logic d, input logic [255:0] grn);
    exp_t e;
    e.row = 4'(row);
    e.st  = 2'(st);
    e.sc  = 12'(sc);
    e.hi  = 12'(hi);
    e.w   = w;
    e.d   = d;
    e.grn = grn;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, state, s);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (exp_q.size() != 0 && n < budget);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Main monitor: one snapshot per step, taken on the negedge after the step edge.
  initial begin : monitor
    logic pend;
    int   idx;
    exp_t e;
    pend = 1'b0;
    idx  = 0;
    forever begin
      @(negedge clock);
      if (pend) begin
        check($sformatf("rec%0d_expected", idx), exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("rec%0d_row", idx), bird_row, e.row);
          check($sformatf("rec%0d_state", idx), state, e.st);
          check($sformatf("rec%0d_score", idx), score, e.sc);
          check($sformatf("rec%0d_hi", idx), hi_score, e.hi);
          check($sformatf("rec%0d_win", idx), win, e.w);
          check($sformatf("rec%0d_die", idx), die, e.d);
          check($sformatf("rec%0d_red", idx), red_pixels, (e.st == 2'd3) ? '0 : bird_px(int'(e.row)));
          check($sformatf("rec%0d_grn", idx), grn_pixels, e.grn);
        end
        idx++;
      end
      pend = step;
    end
  end

  // Second-instance monitor: one score snapshot per win pulse.
  initial begin : monitor1
    exp1_t e;
    forever begin
      @(negedge clock);
      if (win1) begin
        win1_cnt++;
        check($sformatf("win%0d_expected", win1_cnt), exp1_q.size() != 0, 1'b1);
        if (exp1_q.size() != 0) begin
          e = exp1_q.pop_front();
          check($sformatf("win%0d_score", win1_cnt), score1, e.sc);
          check($sformatf("win%0d_hi", win1_cnt), hi_score1, e.hi);
        end
      end
    end
  end

  initial begin : stimulus
    int nstep;
    int cnt;
    int n;
    exp1_t e1;

    reset = 1'b0; run = 1'b0; up = 1'b0; tree_pattern = '0;
    reset1 = 1'b0; run1 = 1'b0; up1 = 1'b0; tree_pattern1 = '0;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b1;
    reset1 = 1'b1;

    // Reset state and idle hold.
    @(negedge clock);
    check("s1_state", state, 2'd0);
    check("s1_row", bird_row, 4'd8);
    check("s1_score", score, 12'h000);
    check("s1_hi", hi_score, 12'h000);
    check("s1_red_bit131", red_pixels, 256'(1) << 131);
    check("s1_grn", grn_pixels, '0);
    check("s1_pulses", {win, die, step}, 3'b000);
    nstep = 0;
    repeat (12) begin
      @(negedge clock);
      nstep += int'(step);
    end
    check("s1_no_step", nstep, 0);
    check("s1_still_idle", state, 2'd0);

    // Free fall to death, then two DEAD steps back to IDLE.
    for (int k = 1; k <= 8; k++) push(8-k, 1, 0, 0, 1'b0, 1'b0, '0);
    push(8, 3, 0, 0, 1'b0, 1'b1, '0);
    push(8, 3, 0, 0, 1'b0, 1'b0, '0);
    push(8, 0, 0, 0, 1'b0, 1'b0, '0);
    run = 1'b1;
    wait_state(2'd3, 200, "s2_reach_dead");
    wait_state(2'd0, 100, "s2_reach_idle");
    run = 1'b0;
    wait_drain(20, "s2_drain");

    // Flap held through a clean round; tree0 goes solid only at the round wrap.
    for (int k = 1; k <= 27; k++) push((k <= 7) ? 8+k : 15, 1, 0, 0, 1'b0, 1'b0, '0);
    push(15, 1, 1, 1, 1'b1, 1'b0, col_mask(15, 16'hFFFF));
    for (int k = 1; k <= 11; k++) push(15, 1, 1, 1, 1'b0, 1'b0, col_mask(15-k, 16'hFFFF));
    push(8, 3, 0, 1, 1'b0, 1'b1, '0);
    push(8, 3, 0, 1, 1'b0, 1'b0, '0);
    push(8, 0, 0, 1, 1'b0, 1'b0, col_mask(15, 16'h0001));
    tree_pattern[15:0] = 16'hFFFF;
    run = 1'b1;
    up  = 1'b1;
    n = 0;
    while (!win && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("s3_win_seen", win, 1'b1);
    tree_pattern[15:0] = 16'h0001;
    wait_state(2'd3, 200, "s4_reach_dead");
    wait_state(2'd0, 100, "s4_reach_idle");
    run = 1'b0;
    up  = 1'b0;
    wait_drain(20, "s4_drain");

    // Pause mid-play with flap requests that must be ignored.
    push(7, 1, 0, 1, 1'b0, 1'b0, col_mask(14, 16'h0001));
    push(6, 1, 0, 1, 1'b0, 1'b0, col_mask(13, 16'h0001));
    run = 1'b1;
    wait_drain(60, "s5_pre_drain");
    run = 1'b0;
    nstep = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      nstep += int'(step);
      if (i == 8) up = 1'b1;
      if (i == 10) up = 1'b0;
    end
    check("s5_pause_no_step", nstep, 0);
    check("s5_pause_state", state, 2'd2);
    check("s5_pause_row", bird_row, 4'd6);
    check("s5_pause_grn", grn_pixels, col_mask(13, 16'h0001));
    check("s5_pause_red", red_pixels, bird_px(6));
    push(5, 1, 0, 1, 1'b0, 1'b0, col_mask(12, 16'h0001));
    push(4, 1, 0, 1, 1'b0, 1'b0, col_mask(11, 16'h0001));
    run = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!step && cnt < 20);
    check("s5_resume_latency", cnt, 2);
    wait_drain(40, "s5_drain");
    run = 1'b0;
    repeat (6) @(negedge clock);
    check("s5_final_pause", state, 2'd2);

    // Single-digit score saturates at 9; reset during DEAD clears the high score.
    for (int k = 1; k <= 10; k++) begin
      e1.sc = 4'((k < 10) ? k : 9);
      e1.hi = 4'((k < 10) ? k : 9);
      exp1_q.push_back(e1);
    end
    run1 = 1'b1;
    up1  = 1'b1;
    n = 0;
    while (exp1_q.size() != 0 && n < 1500) begin
      @(negedge clock);
      n++;
    end
    check("s6_wins_drained", exp1_q.size(), 0);
    up1 = 1'b0;
    n = 0;
    while (!die1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("s6_die_seen", die1, 1'b1);
    check("s6_win_count", win1_cnt, 10);
    check("s6_dead_state", state1, 2'd3);
    check("s6_dead_score", score1, 4'd0);
    check("s6_dead_hi", hi_score1, 4'd9);
    reset1 = 1'b0;
    @(posedge clock);
    #1;
    reset1 = 1'b1;
    run1   = 1'b0;
    @(negedge clock);
    check("s6_reset_state", state1, 2'd0);
    check("s6_reset_hi", hi_score1, 4'd0);
    check("s6_reset_score", score1, 4'd0);
    check("s6_reset_row", bird_row1, 4'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
